// File: rtl/enemy_wave_if.sv
// Bundle between the enemy wave controller and its surroundings: collision and frame
// inputs from upstream, speed/respawn/score outputs towards the movers and HUD.
interface enemy_wave_if #(
    parameter int NUM_ENEMIES = 3
);
  logic                   startOfFrame;
  logic                   startGame;
  logic                   pause;
  logic [NUM_ENEMIES-1:0] enemyHit;
  logic [10:0]            enemySpeed;
  logic                   restart_loc;
  logic [3:0]             wave;
  logic                   waveCleared;
  logic                   killPulse;
  logic [7:0]             killCount;
  logic                   allWavesDone;

  modport master (
    output startOfFrame, startGame, pause, enemyHit,
    input  enemySpeed, restart_loc, wave, waveCleared, killPulse, killCount, allWavesDone
  );

  modport slave (
    input  startOfFrame, startGame, pause, enemyHit,
    output enemySpeed, restart_loc, wave, waveCleared, killPulse, killCount, allWavesDone
  );
endinterface

// File: rtl/enemy_wave_controller.sv
// Wave sequencer for the enemy movers: tracks kills per wave, waits a frame-counted
// delay after a cleared wave, then respawns the enemies faster until the last wave is won.
module enemy_wave_controller #(
    parameter int NUM_ENEMIES       = 3,
    parameter int BASE_SPEED        = 64,
    parameter int SPEED_STEP        = 16,
    parameter int MAX_SPEED         = 192,
    parameter int WAVE_DELAY_FRAMES = 60,
    parameter int MAX_WAVES         = 8
) (
    input logic         clk,
    input logic         resetN,
    enemy_wave_if.slave bus
);

  localparam int FCW = (WAVE_DELAY_FRAMES > 1) ? $clog2(WAVE_DELAY_FRAMES) : 1;
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(WAVE_DELAY_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESPAWN    = 3'd1,
    ST_PLAY       = 3'd2,
    ST_CLEAR_WAIT = 3'd3,
    ST_WIN        = 3'd4
  } state_t;

  function automatic logic [7:0] popcount(input logic [NUM_ENEMIES-1:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

  state_t                 state_r, next_state_s;
  logic [NUM_ENEMIES-1:0] killed_mask_r, killed_mask_s;
  logic [FCW-1:0]         frame_cnt_r, frame_cnt_s;
  logic [10:0]            speed_r, speed_s;
  logic [3:0]             wave_r, wave_s;
  logic                   restart_r, restart_s;
  logic                   wave_cleared_r, wave_cleared_s;
  logic                   kill_pulse_r, kill_pulse_s;
  logic [7:0]             kill_count_r, kill_count_s;
  logic                   all_done_r, all_done_s;

  logic [NUM_ENEMIES-1:0] new_kill_s, mask_upd_s;
  logic                   all_killed_s, frame_tick_s, last_frame_s, last_wave_s;
  logic [8:0]             kill_sum_s;
  logic [11:0]            speed_sum_s;

  assign new_kill_s   = bus.enemyHit & ~killed_mask_r;
  assign mask_upd_s   = killed_mask_r | new_kill_s;
  assign all_killed_s = &mask_upd_s;
  assign frame_tick_s = bus.startOfFrame & ~bus.pause;
  assign last_frame_s = (frame_cnt_r == LAST_FRAME);
  assign last_wave_s  = (wave_r == 4'(MAX_WAVES));
  assign kill_sum_s   = {1'b0, kill_count_r} + {1'b0, popcount(new_kill_s)};
  // 12-bit sum keeps the increment from wrapping before it is clamped.
  assign speed_sum_s  = {1'b0, speed_r} + 12'(SPEED_STEP);

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_WIN: begin
        if (bus.startGame) next_state_s = ST_RESPAWN;
        else               next_state_s = state_r;
      end
      ST_RESPAWN: next_state_s = ST_PLAY;
      ST_PLAY: begin
        if (all_killed_s) next_state_s = ST_CLEAR_WAIT;
        else              next_state_s = ST_PLAY;
      end
      ST_CLEAR_WAIT: begin
        if (frame_tick_s && last_frame_s) next_state_s = last_wave_s ? ST_WIN : ST_RESPAWN;
        else                              next_state_s = ST_CLEAR_WAIT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    killed_mask_s  = killed_mask_r;
    frame_cnt_s    = frame_cnt_r;
    speed_s        = speed_r;
    wave_s         = wave_r;
    kill_count_s   = kill_count_r;
    all_done_s     = all_done_r;
    restart_s      = 1'b0;
    wave_cleared_s = 1'b0;
    kill_pulse_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_WIN: begin
        if (bus.startGame) begin
          wave_s       = 4'd1;
          speed_s      = 11'(BASE_SPEED);
          kill_count_s = 8'd0;
          all_done_s   = 1'b0;
          restart_s    = 1'b1;
        end else begin
          wave_s = wave_r;
        end
      end
      ST_RESPAWN: killed_mask_s = '0;
      ST_PLAY: begin
        if (new_kill_s != '0) begin
          killed_mask_s = mask_upd_s;
          kill_pulse_s  = 1'b1;
          kill_count_s  = kill_sum_s[8] ? 8'd255 : kill_sum_s[7:0];
          if (all_killed_s) begin
            wave_cleared_s = 1'b1;
            frame_cnt_s    = '0;
          end else begin
            frame_cnt_s = frame_cnt_r;
          end
        end else begin
          killed_mask_s = killed_mask_r;
        end
      end
      ST_CLEAR_WAIT: begin
        if (frame_tick_s) begin
          if (!last_frame_s) begin
            frame_cnt_s = frame_cnt_r + {{(FCW-1){1'b0}}, 1'b1};
          end else if (last_wave_s) begin
            all_done_s = 1'b1;
          end else begin
            wave_s    = wave_r + 4'd1;
            speed_s   = (speed_sum_s > 12'(MAX_SPEED)) ? 11'(MAX_SPEED) : speed_sum_s[10:0];
            restart_s = 1'b1;
          end
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      default: killed_mask_s = '0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      killed_mask_r  <= '0;
      frame_cnt_r    <= '0;
      speed_r        <= 11'(BASE_SPEED);
      wave_r         <= 4'd0;
      restart_r      <= 1'b0;
      wave_cleared_r <= 1'b0;
      kill_pulse_r   <= 1'b0;
      kill_count_r   <= 8'd0;
      all_done_r     <= 1'b0;
    end else begin
      killed_mask_r  <= killed_mask_s;
      frame_cnt_r    <= frame_cnt_s;
      speed_r        <= speed_s;
      wave_r         <= wave_s;
      restart_r      <= restart_s;
      wave_cleared_r <= wave_cleared_s;
      kill_pulse_r   <= kill_pulse_s;
      kill_count_r   <= kill_count_s;
      all_done_r     <= all_done_s;
    end
  end

  assign bus.enemySpeed   = speed_r;
  assign bus.restart_loc  = restart_r;
  assign bus.wave         = wave_r;
  assign bus.waveCleared  = wave_cleared_r;
  assign bus.killPulse    = kill_pulse_r;
  assign bus.killCount    = kill_count_r;
  assign bus.allWavesDone = all_done_r;

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Directed bench: default-parameter controller for the wave sequence, plus a fast
// (1-frame delay, large step) instance to exercise the speed ceiling.
module tb_enemy_wave_controller;

  logic clk;
  logic resetN;
  int   checks;
  int   errors;

  enemy_wave_if #(.NUM_ENEMIES(3)) bus1 ();
  enemy_wave_if #(.NUM_ENEMIES(3)) bus2 ();

  enemy_wave_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus1)
  );

  enemy_wave_controller #(
    .SPEED_STEP        (48),
    .WAVE_DELAY_FRAMES (1)
  ) dut_fast (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One frame = startOfFrame pulse plus three quiet cycles; counts restart_loc highs.
  task automatic run_frames(input int n, input logic p, output int restarts);
    restarts = 0;
    for (int i = 0; i < n; i++) begin
      bus1.pause        = p;
      bus1.startOfFrame = 1'b1;
      step();
      bus1.startOfFrame = 1'b0;
      if (bus1.restart_loc) restarts++;
      repeat (3) begin
        step();
        if (bus1.restart_loc) restarts++;
      end
    end
    bus1.pause = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) step();
    chk("rst_speed", int'(bus1.enemySpeed), 64);
    chk("rst_restart", int'(bus1.restart_loc), 0);
    chk("rst_wave", int'(bus1.wave), 0);
    chk("rst_cleared", int'(bus1.waveCleared), 0);
    chk("rst_killpulse", int'(bus1.killPulse), 0);
    chk("rst_killcount", int'(bus1.killCount), 0);
    chk("rst_alldone", int'(bus1.allWavesDone), 0);
    resetN = 1'b1;
    step();
  endtask

  task automatic test_start();
    bus1.enemyHit = 3'b111;
    step();
    chk("idle_hit_killcount", int'(bus1.killCount), 0);
    chk("idle_hit_killpulse", int'(bus1.killPulse), 0);
    bus1.enemyHit  = 3'b000;
    bus1.startGame = 1'b1;
    step();
    bus1.startGame = 1'b0;
    chk("start_restart", int'(bus1.restart_loc), 1);
    chk("start_wave", int'(bus1.wave), 1);
    chk("start_speed", int'(bus1.enemySpeed), 64);
    step();
    chk("start_restart_drop", int'(bus1.restart_loc), 0);
  endtask

  task automatic test_hold_kill();
    int pulses;
    int cleared;
    pulses  = 0;
    cleared = 0;
    bus1.enemyHit = 3'b001;
    repeat (20) begin
      step();
      if (bus1.killPulse) pulses++;
      if (bus1.waveCleared) cleared++;
    end
    bus1.enemyHit = 3'b000;
    chk("hold_pulses", pulses, 1);
    chk("hold_cleared", cleared, 0);
    chk("hold_killcount", int'(bus1.killCount), 1);
  endtask

  task automatic test_wave_clear();
    bus1.enemyHit = 3'b110;
    step();
    bus1.enemyHit = 3'b000;
    chk("clear_killcount", int'(bus1.killCount), 3);
    chk("clear_cleared", int'(bus1.waveCleared), 1);
    chk("clear_killpulse", int'(bus1.killPulse), 1);
    step();
    chk("clear_cleared_drop", int'(bus1.waveCleared), 0);
    bus1.enemyHit = 3'b111;
    repeat (4) step();
    bus1.enemyHit = 3'b000;
    chk("wait_hit_killcount", int'(bus1.killCount), 3);
    chk("wait_hit_killpulse", int'(bus1.killPulse), 0);
  endtask

  task automatic test_pause_delay();
    int r1, r2, r3;
    run_frames(10, 1'b0, r1);
    run_frames(10, 1'b1, r2);
    run_frames(49, 1'b0, r3);
    chk("pause_early_restart", r1 + r2 + r3, 0);
    chk("pause_wave_hold", int'(bus1.wave), 1);
    bus1.startOfFrame = 1'b1;
    step();
    bus1.startOfFrame = 1'b0;
    chk("delay_restart", int'(bus1.restart_loc), 1);
    chk("delay_wave", int'(bus1.wave), 2);
    chk("delay_speed", int'(bus1.enemySpeed), 80);
    step();
    chk("delay_restart_drop", int'(bus1.restart_loc), 0);
  endtask

  task automatic test_all_waves();
    int r;
    for (int w = 2; w <= 8; w++) begin
      bus1.enemyHit = 3'b111;
      step();
      bus1.enemyHit = 3'b000;
      chk("waves_cleared", int'(bus1.waveCleared), 1);
      run_frames(60, 1'b0, r);
      if (w < 8) begin
        chk("waves_restart", r, 1);
        chk("waves_wave", int'(bus1.wave), w + 1);
        chk("waves_speed", int'(bus1.enemySpeed), 64 + 16 * w);
      end else begin
        chk("win_no_restart", r, 0);
        chk("win_alldone", int'(bus1.allWavesDone), 1);
        chk("win_wave", int'(bus1.wave), 8);
        chk("win_speed", int'(bus1.enemySpeed), 176);
      end
    end
    chk("win_killcount", int'(bus1.killCount), 24);
    bus1.enemyHit = 3'b111;
    step();
    bus1.enemyHit = 3'b000;
    chk("win_hit_killcount", int'(bus1.killCount), 24);
  endtask

  task automatic test_restart_game();
    bus1.startGame = 1'b1;
    step();
    bus1.startGame = 1'b0;
    chk("regame_restart", int'(bus1.restart_loc), 1);
    chk("regame_wave", int'(bus1.wave), 1);
    chk("regame_speed", int'(bus1.enemySpeed), 64);
    chk("regame_killcount", int'(bus1.killCount), 0);
    chk("regame_alldone", int'(bus1.allWavesDone), 0);
    step();
  endtask

  task automatic test_speed_cap();
    int exp_s;
    bus2.startGame = 1'b1;
    step();
    bus2.startGame = 1'b0;
    step();
    for (int w = 1; w <= 7; w++) begin
      bus2.enemyHit = 3'b111;
      step();
      bus2.enemyHit     = 3'b000;
      bus2.startOfFrame = 1'b1;
      step();
      bus2.startOfFrame = 1'b0;
      exp_s = 64 + 48 * w;
      if (exp_s > 192) exp_s = 192;
      chk("cap_restart", int'(bus2.restart_loc), 1);
      chk("cap_wave", int'(bus2.wave), w + 1);
      chk("cap_speed", int'(bus2.enemySpeed), exp_s);
      step();
    end
  endtask

  task automatic test_reset_mid();
    int r;
    bus1.enemyHit = 3'b111;
    step();
    bus1.enemyHit = 3'b000;
    run_frames(5, 1'b0, r);
    chk("mid_killcount_pre", int'(bus1.killCount), 3);
    resetN = 1'b0;
    #1;
    chk("mid_speed", int'(bus1.enemySpeed), 64);
    chk("mid_wave", int'(bus1.wave), 0);
    chk("mid_killcount", int'(bus1.killCount), 0);
    chk("mid_restart", int'(bus1.restart_loc), 0);
    step();
    resetN = 1'b1;
    run_frames(60, 1'b0, r);
    chk("mid_idle_no_restart", r, 0);
    chk("mid_idle_wave", int'(bus1.wave), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    bus1.startOfFrame = 1'b0;
    bus1.startGame    = 1'b0;
    bus1.pause        = 1'b0;
    bus1.enemyHit     = 3'b000;
    bus2.startOfFrame = 1'b0;
    bus2.startGame    = 1'b0;
    bus2.pause        = 1'b0;
    bus2.enemyHit     = 3'b000;
    test_reset();
    test_start();
    test_hold_kill();
    test_wave_clear();
    test_pause_delay();
    test_all_waves();
    test_restart_game();
    test_speed_cap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
